// File: rtl/fp_add_pipe.sv
// fp_add_pipe: multi-cycle IEEE-754-style add/subtract with valid/ready on both sides.
// Round toward zero, denormal inputs and tiny results flush to zero, one operation in flight.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         ovf,
   output logic         inv
);
   localparam int MW  = MAN_W + 3;   // hidden, fraction, guard, sticky
   localparam int SW  = MAN_W + 4;   // MW plus carry
   localparam int LZW = $clog2(SW) + 1;
   localparam int EW  = EXP_W + 2;   // exponent workspace, top bit is the sign
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
   state_t state_q, state_d;

   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             sign_big_q, sign_big_d, sign_sml_q, sign_sml_d;
   logic [EXP_W-1:0] exp_big_q, exp_big_d;
   logic [MW-1:0]    man_big_q, man_big_d, man_sml_q, man_sml_d;
   logic             spec_q, spec_d, spec_inv_q, spec_inv_d;
   logic [W-1:0]     spec_res_q, spec_res_d;
   logic [SW-1:0]    sum_q, sum_d;
   logic [W-1:0]     out_q, out_d;
   logic             ovf_q, ovf_d, inv_q, inv_d;

   assign out = out_q;
   assign ovf = ovf_q;
   assign inv = inv_q;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_ALIGN;
         end
         S_ALIGN: state_d = S_ADD;
         S_ADD:   state_d = S_NORM;
         S_NORM:  state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (state_q == S_IDLE && in_valid) begin
         a_d = a;
         b_d = {b[W-1] ^ sub, b[W-2:0]};
      end
   end

   // Unpack, classify specials, order by magnitude and align the smaller operand.
   logic [EXP_W-1:0] ea, eb, exp_sml, diff;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
   logic [MW-1:0]    ma, mb, sml_full, sml_sh, sml_lost;

   always_comb begin
      ea     = a_q[W-2:MAN_W];
      fa     = a_q[MAN_W-1:0];
      eb     = b_q[W-2:MAN_W];
      fb     = b_q[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_MAX) && (fa == '0);
      b_inf  = (eb == EXP_MAX) && (fb == '0);
      a_nan  = (ea == EXP_MAX) && (fa != '0);
      b_nan  = (eb == EXP_MAX) && (fb != '0);
      ma     = a_zero ? '0 : {1'b1, fa, 2'b00};
      mb     = b_zero ? '0 : {1'b1, fb, 2'b00};
      a_ge_b = {ea, ma} >= {eb, mb};
      if (a_ge_b) begin
         sign_big_d = a_q[W-1];
         sign_sml_d = b_q[W-1];
         exp_big_d  = ea;
         exp_sml    = eb;
         man_big_d  = ma;
         sml_full   = mb;
      end else begin
         sign_big_d = b_q[W-1];
         sign_sml_d = a_q[W-1];
         exp_big_d  = eb;
         exp_sml    = ea;
         man_big_d  = mb;
         sml_full   = ma;
      end
      diff     = exp_big_d - exp_sml;
      sml_sh   = sml_full >> diff;
      sml_lost = sml_full & ~({MW{1'b1}} << diff);
      if (int'(diff) >= MW) man_sml_d = '0;
      else                  man_sml_d = {sml_sh[MW-1:1], sml_sh[0] | (|sml_lost)};

      spec_d     = 1'b0;
      spec_inv_d = 1'b0;
      spec_res_d = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]))) begin
         spec_d     = 1'b1;
         spec_inv_d = 1'b1;
         spec_res_d = QNAN;
      end else if (a_inf) begin
         spec_d     = 1'b1;
         spec_res_d = {a_q[W-1], EXP_MAX, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_d     = 1'b1;
         spec_res_d = {b_q[W-1], EXP_MAX, {MAN_W{1'b0}}};
      end
   end

   // Big magnitude is first, so the difference never goes negative.
   always_comb begin
      if (sign_big_q == sign_sml_q) sum_d = {1'b0, man_big_q} + {1'b0, man_sml_q};
      else                          sum_d = {1'b0, man_big_q} - {1'b0, man_sml_q};
   end

   logic [LZW-1:0]   lzc;
   logic [EW-1:0]    exp_n;
   logic [MAN_W-1:0] frac_n;

   always_comb begin
      lzc = '0;
      for (int i = 0; i < MW; i++) begin
         if (sum_q[i]) lzc = LZW'(MW - 1 - i);
      end
      if (sum_q[SW-1]) begin
         exp_n  = {2'b00, exp_big_q} + EW'(1);
         frac_n = MAN_W'(sum_q >> 3);
      end else begin
         exp_n  = {2'b00, exp_big_q} - {{(EW-LZW){1'b0}}, lzc};
         frac_n = MAN_W'(sum_q[MW-1:0] << lzc >> 2);
      end

      out_d = '0;
      ovf_d = 1'b0;
      inv_d = 1'b0;
      if (spec_q) begin
         out_d = spec_res_q;
         inv_d = spec_inv_q;
      end else if (sum_q == '0) begin
         out_d = {sign_big_q & sign_sml_q, {(W-1){1'b0}}};
      end else if (!exp_n[EW-1] && (exp_n[EW-2:0] >= {1'b0, EXP_MAX})) begin
         out_d = {sign_big_q, EXP_MAX, {MAN_W{1'b0}}};
         ovf_d = 1'b1;
      end else if (exp_n[EW-1] || (exp_n == '0)) begin
         out_d = {sign_big_q, {(W-1){1'b0}}};
      end else begin
         out_d = {sign_big_q, exp_n[EXP_W-1:0], frac_n};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sign_big_q <= 1'b0;
         sign_sml_q <= 1'b0;
         exp_big_q  <= '0;
         man_big_q  <= '0;
         man_sml_q  <= '0;
         spec_q     <= 1'b0;
         spec_inv_q <= 1'b0;
         spec_res_q <= '0;
         sum_q      <= '0;
         out_q      <= '0;
         ovf_q      <= 1'b0;
         inv_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         if (state_q == S_ALIGN) begin
            sign_big_q <= sign_big_d;
            sign_sml_q <= sign_sml_d;
            exp_big_q  <= exp_big_d;
            man_big_q  <= man_big_d;
            man_sml_q  <= man_sml_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
         end
         if (state_q == S_ADD) sum_q <= sum_d;
         if (state_q == S_NORM) begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            inv_q <= inv_d;
         end
      end
   end
endmodule
